lfsr_sequencer: RTL and testbench

//  Avalon-MM-controlled sequencer for a Galois LFSR whose value drives the 5-bit PIO input port (in_port).

---
 rtl/lfsr_seq_pkg.sv | 31 +++
 rtl/lfsr_core.sv | 67 ++++++
 rtl/lfsr_sequencer.sv | 158 +++++++++++++++
 tb/tb_lfsr_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared register map, CTRL bit positions and sequencer state encoding.
package lfsr_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned PRESC_W = 16;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_SEED  = 2'd1;
  localparam logic [1:0] ADDR_TAPS  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  // CTRL write bits
  localparam int unsigned CTRL_RUN        = 0;
  localparam int unsigned CTRL_STEP       = 1;
  localparam int unsigned CTRL_LOAD       = 2;
  localparam int unsigned CTRL_IRQ_CLR    = 5;
  localparam int unsigned CTRL_LOCKUP_CLR = 6;

  // CTRL read bits
  localparam int unsigned CTRL_BUSY   = 3;
  localparam int unsigned CTRL_LOCKUP = 4;
  localparam int unsigned CTRL_IRQ    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } seq_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with load, advance and all-zero recovery.
module lfsr_core #(
  parameter int unsigned       WIDTH        = 5,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(5'h01)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic             lockup_clr_i,
  output logic [WIDTH-1:0] value_o,
  output logic             step_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] adv_c;

  // Next state: load beats advance; a zero result is replaced by the default seed.
  always_comb begin
    value_d   = value_q;
    step_d    = 1'b0;
    lockup_d  = lockup_q;
    shifted_c = value_q >> 1;
    adv_c     = value_q[0] ? (shifted_c ^ taps_i) : shifted_c;
    if (lockup_clr_i) lockup_d = 1'b0;
    if (load_i) begin
      if (seed_i == '0) begin
        value_d  = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        value_d = seed_i;
      end
    end else if (advance_i) begin
      step_d = 1'b1;
      if (adv_c == '0) begin
        value_d  = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        value_d = adv_c;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= DEFAULT_SEED;
      step_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      step_q   <= step_d;
      lockup_q <= lockup_d;
    end
  end

  assign value_o  = value_q;
  assign step_o   = step_q;
  assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_sequencer.sv
// Avalon-MM register file, pacing FSM and burst/irq control around lfsr_core.
module lfsr_sequencer
  import lfsr_seq_pkg::*;
#(
  parameter int unsigned      WIDTH        = 5,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(5'h01),
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(5'h14),
  parameter int unsigned      STEP_DIV     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [WIDTH-1:0]  lfsr_value,
  output logic              lfsr_step,
  output logic              irq
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  logic               run_q;
  logic [WIDTH-1:0]   seed_q;
  logic [WIDTH-1:0]   taps_q;
  logic [DATA_W-1:0]  readdata_q;
  seq_state_e         state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [COUNT_W-1:0] count_q;
  logic               irq_q;
  logic               lockup;

  logic               wr_ctrl_c, step_req_c, load_c, irq_clr_c, lockup_clr_c;
  logic               count_wr_c, presc_hit_c, advance_c;
  logic [DATA_W-1:0]  rd_c;
  logic               unused_wd_c;

  assign wr_ctrl_c    = write && (address == ADDR_CTRL);
  assign step_req_c   = wr_ctrl_c && writedata[CTRL_STEP];
  assign load_c       = wr_ctrl_c && writedata[CTRL_LOAD];
  assign irq_clr_c    = wr_ctrl_c && writedata[CTRL_IRQ_CLR];
  assign lockup_clr_c = wr_ctrl_c && writedata[CTRL_LOCKUP_CLR];
  assign count_wr_c   = write && (address == ADDR_COUNT) && (writedata[COUNT_W-1:0] != '0);
  assign presc_hit_c  = (presc_q == PRESC_LAST);
  assign unused_wd_c  = ^writedata[DATA_W-1:COUNT_W];

  // Advance request for this edge; a load in the same cycle freezes the FSM.
  always_comb begin
    advance_c = 1'b0;
    if (!load_c) begin
      case (state_q)
        ST_IDLE:  advance_c = step_req_c;
        ST_RUN:   advance_c = run_q && presc_hit_c;
        ST_BURST: advance_c = presc_hit_c;
        default:  advance_c = 1'b0;
      endcase
    end
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_c = '0;
    case (address)
      ADDR_CTRL: begin
        rd_c[CTRL_RUN]    = run_q;
        rd_c[CTRL_BUSY]   = (state_q != ST_IDLE);
        rd_c[CTRL_LOCKUP] = lockup;
        rd_c[CTRL_IRQ]    = irq_q;
      end
      ADDR_SEED: rd_c[WIDTH-1:0]   = seed_q;
      ADDR_TAPS: rd_c[WIDTH-1:0]   = taps_q;
      default:   rd_c[COUNT_W-1:0] = count_q;
    endcase
  end

  // Software-visible registers and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      seed_q     <= DEFAULT_SEED;
      taps_q     <= DEFAULT_TAPS;
      readdata_q <= '0;
    end else begin
      if (wr_ctrl_c) run_q <= writedata[CTRL_RUN];
      if (write && (address == ADDR_SEED)) seed_q <= writedata[WIDTH-1:0];
      if (write && (address == ADDR_TAPS)) taps_q <= writedata[WIDTH-1:0];
      readdata_q <= rd_c;
    end
  end

  // Sequencer FSM with prescaler, burst counter and sticky irq (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (irq_clr_c) irq_q <= 1'b0;
      if (!load_c) begin
        case (state_q)
          ST_IDLE: begin
            if (run_q) begin
              state_q <= ST_RUN;
              presc_q <= '0;
            end else if (count_wr_c) begin
              state_q <= ST_BURST;
              presc_q <= '0;
              count_q <= writedata[COUNT_W-1:0];
            end
          end
          ST_RUN: begin
            if (!run_q) begin
              state_q <= ST_IDLE;
            end else if (presc_hit_c) begin
              presc_q <= '0;
            end else begin
              presc_q <= presc_q + PRESC_W'(1);
            end
          end
          ST_BURST: begin
            if (presc_hit_c) begin
              presc_q <= '0;
              count_q <= count_q - COUNT_W'(1);
              if (count_q == COUNT_W'(1)) begin
                irq_q   <= 1'b1;
                state_q <= run_q ? ST_RUN : ST_IDLE;
              end
            end else begin
              presc_q <= presc_q + PRESC_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  lfsr_core #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .advance_i    (advance_c),
    .load_i       (load_c),
    .seed_i       (seed_q),
    .taps_i       (taps_q),
    .lockup_clr_i (lockup_clr_c),
    .value_o      (lfsr_value),
    .step_o       (lfsr_step),
    .lockup_o     (lockup)
  );

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Bench for lfsr_sequencer: two instances (STEP_DIV 1 and 4) on one bus, checked against a
// transaction-level LFSR model.
module tb_lfsr_sequencer;

  localparam int unsigned W = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   rd1, rd4;
  logic [W-1:0]  v1, v4;
  logic          st1, st4, irq1, irq4;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int q1[$];
  int q4[$];

  // expected software-visible state
  logic [W-1:0] m_val, m_seed, m_taps;
  logic         m_lock;

  always #5 clk = ~clk;

  lfsr_sequencer #(.WIDTH(W), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd1), .lfsr_value(v1), .lfsr_step(st1), .irq(irq1));

  lfsr_sequencer #(.WIDTH(W), .STEP_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd4), .lfsr_value(v4), .lfsr_step(st4), .irq(irq4));

  // record the cycle number of every step pulse
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (st1) q1.push_back(cyc);
    if (st4) q4.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] raw_next(input logic [W-1:0] v, input logic [W-1:0] t);
    logic [W-1:0] r;
    r = v / 2;
    if (v % 2 == 1) r = r ^ t;
    return r;
  endfunction

  // model one advance of the expected LFSR value
  task automatic model_adv(inout logic [W-1:0] v, inout logic lk);
    logic [W-1:0] n;
    n = raw_next(v, m_taps);
    if (n == 0) begin
      v  = 1;
      lk = 1'b1;
    end else begin
      v = n;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r1, output logic [31:0] r4);
    @(negedge clk);
    address = a;
    @(negedge clk);
    r1 = rd1; r4 = rd4;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r1, r4;
    bus_read(a, r1, r4);
    check({tag, "_d1"}, r1, exp);
    check({tag, "_d4"}, r4, exp);
  endtask

  task automatic model_reset();
    m_val = 1; m_seed = 1; m_taps = 5'h14; m_lock = 1'b0;
  endtask

  task automatic do_load();
    bus_write(2'd0, 32'h4);
    if (m_seed == 0) begin
      m_val = 1; m_lock = 1'b1;
    end else begin
      m_val = m_seed;
    end
    check("load_val_d1", 32'(v1), 32'(m_val));
    check("load_val_d4", 32'(v4), 32'(m_val));
    check("load_nostep", 32'({st1, st4}), 32'd0);
  endtask

  task automatic do_step();
    bus_write(2'd0, 32'h2);
    model_adv(m_val, m_lock);
    check("step_val_d1", 32'(v1), 32'(m_val));
    check("step_val_d4", 32'(v4), 32'(m_val));
    check("step_pulse", 32'({st1, st4}), 32'd3);
    @(negedge clk);
    check("step_oneclk", 32'({st1, st4}), 32'd0);
  endtask

  task automatic gap_check(input string tag, input int q[$], input int gap);
    int bad = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != gap) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic do_burst(input int n);
    q1.delete(); q4.delete();
    bus_write(2'd3, 32'(n));
    for (int i = 0; i < n * 4 + 20 && !irq4; i++) @(negedge clk);
    #1;
    check("burst_done_d4", 32'(irq4), 32'd1);
    check("burst_irq_d1", 32'(irq1), 32'd1);
    check("burst_n_d1", 32'(q1.size()), 32'(n));
    check("burst_n_d4", 32'(q4.size()), 32'(n));
    gap_check("burst_gap_d1", q1, 1);
    gap_check("burst_gap_d4", q4, 4);
    for (int i = 0; i < n; i++) model_adv(m_val, m_lock);
    check("burst_val_d1", 32'(v1), 32'(m_val));
    check("burst_val_d4", 32'(v4), 32'(m_val));
    read_check("burst_count", 2'd3, 32'd0);
    read_check("burst_ctrl", 2'd0, 32'h20 | (32'(m_lock) << 4));
    bus_write(2'd0, 32'h20);
    check("irq_clr", 32'({irq1, irq4}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e1, e4, s, t;
    logic         lk_tmp;
    int           n;

    reset = 1'b1; write = 1'b0; address = '0; writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_val", 32'({v1, v4}), 32'({5'h01, 5'h01}));
    check("rst_step_irq", 32'({st1, st4, irq1, irq4}), 32'd0);
    check("rst_rd", rd1 | rd4, 32'd0);
    reset = 1'b0;

    read_check("rst_seed", 2'd1, 32'h01);
    read_check("rst_taps", 2'd2, 32'h14);
    read_check("rst_ctrl", 2'd0, 32'h00);

    // single steps from the default seed: 0x14, 0x0A, 0x05
    repeat (3) do_step();
    check("step3_const", 32'(v1), 32'h05);

    // full-period burst returns to the seed
    do_load();
    do_burst(31);
    check("period_const", 32'(v1), 32'h01);

    // zero seed recovery and lockup flag
    bus_write(2'd1, 32'h0); m_seed = 0;
    do_load();
    read_check("lock_ctrl", 2'd0, 32'h10);
    bus_write(2'd0, 32'h40); m_lock = 1'b0;
    read_check("lock_clr", 2'd0, 32'h00);

    // free run with stray step and COUNT writes that must be ignored
    bus_write(2'd1, 32'h1); m_seed = 1;
    do_load();
    q1.delete(); q4.delete();
    bus_write(2'd0, 32'h1);
    repeat (6) @(negedge clk);
    bus_write(2'd0, 32'h3);
    repeat (3) @(negedge clk);
    bus_write(2'd3, 32'd5);
    repeat (10) @(negedge clk);
    bus_write(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("run_n_d1", 32'(q1.size()), 32'd24);
    check("run_n_d4", 32'(q4.size()), 32'd6);
    gap_check("run_gap_d1", q1, 1);
    gap_check("run_gap_d4", q4, 4);
    e1 = m_val; e4 = m_val; lk_tmp = 1'b0;
    for (int i = 0; i < q1.size(); i++) model_adv(e1, lk_tmp);
    for (int i = 0; i < q4.size(); i++) model_adv(e4, lk_tmp);
    check("run_val_d1", 32'(v1), 32'(e1));
    check("run_val_d4", 32'(v4), 32'(e4));
    read_check("run_stop_ctrl", 2'd0, 32'h00);
    read_check("run_count", 2'd3, 32'd0);
    do_load();

    // randomized seeds, taps, steps and bursts
    for (int it = 0; it < 12; it++) begin
      s = W'($urandom_range(0, 31));
      t = W'($urandom_range(0, 31));
      bus_write(2'd1, 32'(s) | 32'hFFFF_FFE0); m_seed = s;
      bus_write(2'd2, 32'(t)); m_taps = t;
      read_check("rnd_seed", 2'd1, 32'(s));
      read_check("rnd_taps", 2'd2, 32'(t));
      do_load();
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) do_step();
        read_check("rnd_ctrl", 2'd0, 32'(m_lock) << 4);
      end else begin
        do_burst($urandom_range(1, 24));
      end
      bus_write(2'd0, 32'h40); m_lock = 1'b0;
    end

    // reset in the middle of a burst
    bus_write(2'd2, 32'h14); m_taps = 5'h14;
    bus_write(2'd1, 32'h3);  m_seed = 5'h3;
    do_load();
    bus_write(2'd3, 32'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_val", 32'({v1, v4}), 32'({5'h01, 5'h01}));
    check("mid_rst_flags", 32'({st1, st4, irq1, irq4}), 32'd0);
    check("mid_rst_rd", rd1 | rd4, 32'd0);
    reset = 1'b0;
    model_reset();
    #1;
    q1.delete(); q4.delete();
    repeat (60) @(negedge clk);
    #1;
    check("mid_rst_nopulse", 32'(q1.size() + q4.size()), 32'd0);
    check("mid_rst_noirq", 32'({irq1, irq4}), 32'd0);
    read_check("mid_rst_ctrl", 2'd0, 32'h00);
    read_check("mid_rst_count", 2'd3, 32'd0);
    read_check("mid_rst_taps", 2'd2, 32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
